// File: rtl/bf_pkg.sv
// Shared types for the brainfuck CPU: op codes (also used by the decoder)
// and the data-unit FSM states. The TRAP state only exists when
// BF_PTR_TRAP_EN is defined.
package bf_pkg;

  typedef enum logic [2:0] {
    OP_INC,
    OP_DEC,
    OP_RIGHT,
    OP_LEFT,
    OP_OUT,
    OP_IN,
    OP_ZCHK
  } bf_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MOD,
    ST_OUT_W,
`ifdef BF_PTR_TRAP_EN
    ST_IN_W,
    ST_TRAP
`else
    ST_IN_W
`endif
  } bf_state_t;

endpackage

// File: rtl/bf_data_unit.sv
// Data-path execution stage of the brainfuck CPU: owns the data pointer,
// performs read-modify-write cell updates through the memory port, handles
// '.' / ',' byte handshakes and reports the current cell's zero flag.
// Optional feature macro: BF_PTR_TRAP_EN (pointer range trap instead of wrap).
module bf_data_unit
  import bf_pkg::*;
#(
  parameter int width_addr = 16,
  parameter int width_data = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  op_valid_in,
  input  bf_op_t                op_in,
  output logic                  op_ready_out,
  output logic                  done_out,
  output logic                  zero_out,
  output logic [width_addr-1:0] ptr_out,
  output logic                  mem_enable_out,
  output logic                  mem_is_write_out,
  output logic [width_addr-1:0] mem_addr_out,
  output logic [width_data-1:0] mem_wdata_out,
  input  logic [width_data-1:0] mem_rdata_in,
  output logic                  out_valid_out,
  output logic [width_data-1:0] out_data_out,
  input  logic                  out_ready_in,
  input  logic                  in_valid_in,
  input  logic [width_data-1:0] in_data_in,
  output logic                  in_ready_out,
  output logic                  trap_out
);

  bf_state_t             state, state_d;
  bf_op_t                op_q, op_d;
  logic [width_addr-1:0] ptr, ptr_d;
  logic                  zero, zero_d;
  logic                  done_q, done_d;   // delayed retire for pointer ops / NOP
  logic                  done_now;         // retire in the current cycle
  logic                  fresh;            // first OUT_W cycle: rdata is live
  logic [width_data-1:0] out_byte;         // OUT byte held for later OUT_W cycles
  logic                  en, wr, op_ready, out_valid, in_ready;
  logic [width_data-1:0] wdata;
`ifdef BF_PTR_TRAP_EN
  logic                  trap, trap_d;
`endif

  // State, pointer, flag and output-byte registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      op_q     <= OP_INC;
      ptr      <= '0;
      zero     <= 1'b1;
      done_q   <= 1'b0;
      fresh    <= 1'b0;
      out_byte <= '0;
`ifdef BF_PTR_TRAP_EN
      trap     <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      ptr    <= ptr_d;
      zero   <= zero_d;
      done_q <= done_d;
      fresh  <= (state == ST_RD);
      if (state == ST_OUT_W && fresh) out_byte <= mem_rdata_in;
`ifdef BF_PTR_TRAP_EN
      trap   <= trap_d;
`endif
    end
  end

  // Next-state and memory/handshake control
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    ptr_d     = ptr;
    zero_d    = zero;
    done_d    = 1'b0;
    done_now  = 1'b0;
    en        = 1'b0;
    wr        = 1'b0;
    wdata     = '0;
    op_ready  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
`ifdef BF_PTR_TRAP_EN
    trap_d    = trap;
`endif
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid_in) begin
          op_d = op_in;
          case (op_in)
            OP_INC, OP_DEC, OP_ZCHK, OP_OUT: state_d = ST_RD;
            OP_IN: state_d = ST_IN_W;
            OP_RIGHT: begin
`ifdef BF_PTR_TRAP_EN
              if (ptr == '1) begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
              end else begin
                ptr_d  = ptr + width_addr'(1);
                done_d = 1'b1;
              end
`else
              ptr_d  = ptr + width_addr'(1);
              done_d = 1'b1;
`endif
            end
            OP_LEFT: begin
`ifdef BF_PTR_TRAP_EN
              if (ptr == '0) begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
              end else begin
                ptr_d  = ptr - width_addr'(1);
                done_d = 1'b1;
              end
`else
              ptr_d  = ptr - width_addr'(1);
              done_d = 1'b1;
`endif
            end
            default: done_d = 1'b1;  // undefined code retires as NOP
          endcase
        end
      end
      ST_RD: begin
        en      = 1'b1;
        state_d = (op_q == OP_OUT) ? ST_OUT_W : ST_MOD;
      end
      ST_MOD: begin
        done_now = 1'b1;
        state_d  = ST_IDLE;
        if (op_q == OP_ZCHK) begin
          zero_d = (mem_rdata_in == '0);
        end else begin
          en     = 1'b1;
          wr     = 1'b1;
          wdata  = (op_q == OP_INC) ? mem_rdata_in + width_data'(1)
                                    : mem_rdata_in - width_data'(1);
          zero_d = (wdata == '0);
        end
      end
      ST_OUT_W: begin
        out_valid = 1'b1;
        if (out_ready_in) begin
          done_now = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_IN_W: begin
        in_ready = 1'b1;
        if (in_valid_in) begin
          en       = 1'b1;
          wr       = 1'b1;
          wdata    = in_data_in;
          zero_d   = (in_data_in == '0);
          done_now = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`ifdef BF_PTR_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;  // only reset leaves
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset cycle must not issue a write or complete a handshake
  assign mem_enable_out   = en & ~reset_in;
  assign mem_is_write_out = wr & ~reset_in;
  assign mem_wdata_out    = wdata;
  assign mem_addr_out     = ptr;
  assign ptr_out          = ptr;
  assign zero_out         = zero;
  assign op_ready_out     = op_ready;
  assign done_out         = (done_now | done_q) & ~reset_in;
  assign out_valid_out    = out_valid & ~reset_in;
  assign out_data_out     = out_valid ? (fresh ? mem_rdata_in : out_byte) : '0;
  assign in_ready_out     = in_ready & ~reset_in;
`ifdef BF_PTR_TRAP_EN
  assign trap_out         = trap;
`else
  assign trap_out         = 1'b0;
`endif

endmodule

// File: tb/tb_bf_data_unit.sv
// Directed self-checking bench for bf_data_unit with a behavioural data
// memory (registered read, garbage on cycles without a read request).
// Honours BF_PTR_TRAP_EN for the pointer-range boundary step.
module tb_bf_data_unit;
  import bf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  bf_op_t      op;
  logic        op_ready, done, zero;
  logic [15:0] ptr;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        trap;

  logic [7:0]  mem [0:65535];
  int          nwr;
  int          n_cmp = 0;
  int          n_bad = 0;

  bf_data_unit #(.width_addr(16), .width_data(8)) dut (
    .clk_in(clk), .reset_in(rst),
    .op_valid_in(op_valid), .op_in(op), .op_ready_out(op_ready),
    .done_out(done), .zero_out(zero), .ptr_out(ptr),
    .mem_enable_out(mem_en), .mem_is_write_out(mem_wr),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata),
    .out_valid_out(out_valid), .out_data_out(out_data), .out_ready_in(out_ready),
    .in_valid_in(in_valid), .in_data_in(in_data), .in_ready_out(in_ready),
    .trap_out(trap)
  );

  always #5 clk = ~clk;

  // Data memory: sync write, registered read valid one cycle after request
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      nwr <= nwr + 1;
    end
    mem_rdata <= (mem_en && !mem_wr) ? mem[mem_addr] : 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present op for one cycle; returns at cycle 1 after accept (+1ns)
  task automatic accept(input bf_op_t o, input string tag);
    @(negedge clk); op_valid = 1'b1; op = o; #1;
    chk({tag, " ready"}, {31'd0, op_ready}, 32'd1);
    @(negedge clk); op_valid = 1'b0; #1;
  endtask

  // Wait (bounded) for done and check cycles from accept to retire
  task automatic wait_done(input int exp_lat, input string tag);
    int lat = 1;
    while (!done && lat < 40) begin @(negedge clk); #1; lat++; end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic run_op(input bf_op_t o, input int exp_lat, input string tag);
    accept(o, tag);
    wait_done(exp_lat, tag);
  endtask

  task automatic idle_cycle();
    @(negedge clk); #1;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    nwr = 0; rst = 1'b1; op_valid = 1'b0; op = OP_INC;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk("rst ptr", ptr, 0);
    chk("rst zero", zero, 1);
    chk("rst trap", trap, 0);
    chk("rst ready", op_ready, 1);
    chk("rst done", done, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);

    // INC x3, DEC x1 at ptr 0
    run_op(OP_INC, 2, "inc1");
    chk("inc1 wr", {mem_en, mem_wr}, 2'b11);
    chk("inc1 wdata", mem_wdata, 8'h01);
    run_op(OP_INC, 2, "inc2");
    run_op(OP_INC, 2, "inc3");
    run_op(OP_DEC, 2, "dec1");
    idle_cycle();
    chk("cell0 is 2", mem[0], 8'h02);
    chk("zero after 2", zero, 0);

    // Down to 0, then underflow and overflow
    run_op(OP_DEC, 2, "dec2");
    run_op(OP_DEC, 2, "dec3");
    idle_cycle();
    chk("cell0 is 0", mem[0], 8'h00);
    chk("zero at 0", zero, 1);
    run_op(OP_DEC, 2, "dec underflow");
    idle_cycle();
    chk("cell0 is FF", mem[0], 8'hFF);
    chk("zero at FF", zero, 0);
    run_op(OP_INC, 2, "inc overflow");
    idle_cycle();
    chk("cell0 wraps 00", mem[0], 8'h00);
    chk("zero after wrap", zero, 1);

    // RIGHT, IN with late source
    run_op(OP_RIGHT, 1, "right");
    chk("ptr 1", ptr, 1);
    accept(OP_IN, "in");
    for (int i = 0; i < 5; i++) begin
      chk("in wait ready", in_ready, 1);
      chk("in wait no mem", mem_en, 0);
      chk("in wait no done", done, 0);
      @(negedge clk); #1;
    end
    in_valid = 1'b1; in_data = 8'h41; #1;
    chk("in write", {mem_en, mem_wr}, 2'b11);
    chk("in wdata", mem_wdata, 8'h41);
    chk("in addr", mem_addr, 1);
    chk("in done", done, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("in ready drops", in_ready, 0);
    chk("cell1 is 41", mem[1], 8'h41);
    chk("zero after in", zero, 0);

    // LEFT, RIGHT, OUT with sink stalled 3 cycles
    run_op(OP_LEFT, 1, "left");
    chk("ptr 0", ptr, 0);
    run_op(OP_RIGHT, 1, "right2");
    accept(OP_OUT, "out");
    chk("out rd", {mem_en, mem_wr}, 2'b10);
    chk("out rd addr", mem_addr, 1);
    chk("out not yet valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("out stall valid", out_valid, 1);
      chk("out stall data", out_data, 8'h41);
      chk("out stall no done", done, 0);
      chk("out stall no mem", mem_en, 0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("out hs valid", out_valid, 1);
    chk("out hs data", out_data, 8'h41);
    chk("out hs done", done, 1);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("out valid drops", out_valid, 0);
    chk("out back idle", op_ready, 1);

    // ZCHK: zero cell then nonzero cell, never writes
    run_op(OP_LEFT, 1, "left2");
    run_op(OP_ZCHK, 2, "zchk0");
    idle_cycle();
    chk("zchk0 zero", zero, 1);
    run_op(OP_RIGHT, 1, "right3");
    w0 = nwr;
    accept(OP_ZCHK, "zchk1");
    chk("zchk1 rd", {mem_en, mem_wr}, 2'b10);
    chk("zchk1 zero before", zero, 1);
    @(negedge clk); #1;
    chk("zchk1 mod done", done, 1);
    chk("zchk1 mod no wr", mem_wr, 0);
    idle_cycle();
    chk("zchk1 zero after", zero, 0);
    chk("zchk1 no writes", nwr - w0, 0);

    // Undefined op retires as NOP
    w0 = nwr;
    run_op(bf_op_t'(3'd7), 1, "nop");
    chk("nop ptr", ptr, 1);
    chk("nop no writes", nwr - w0, 0);

    // Pointer boundary: LEFT at ptr 0
    run_op(OP_LEFT, 1, "left to 0");
    chk("ptr back 0", ptr, 0);
`ifdef BF_PTR_TRAP_EN
    accept(OP_LEFT, "left trap");
    for (int i = 0; i < 4; i++) begin
      chk("trap set", trap, 1);
      chk("trap not ready", op_ready, 0);
      chk("trap no done", done, 0);
      chk("trap ptr", ptr, 0);
      @(negedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("trap cleared", trap, 0);
    chk("trap ready again", op_ready, 1);
`else
    run_op(OP_LEFT, 1, "left wrap");
    chk("ptr wraps FFFF", ptr, 16'hFFFF);
    chk("no trap", trap, 0);
    run_op(OP_RIGHT, 1, "right wrap");
    chk("ptr wraps 0", ptr, 0);
`endif

    // Reset during MOD of INC at ptr 1
    run_op(OP_RIGHT, 1, "right4");
    w0 = nwr;
    accept(OP_INC, "inc rst");
    @(negedge clk); rst = 1'b1; #1;
    chk("rst mod no en", mem_en, 0);
    chk("rst mod no done", done, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst mod no writes", nwr - w0, 0);
    chk("rst mod cell1", mem[1], 8'h41);
    chk("rst mod ptr", ptr, 0);
    chk("rst mod zero", zero, 1);
    chk("rst mod ready", op_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared=%0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
